lif_neuron: RTL and testbench

Leaky integrate-and-fire neuron for the RSNN core. It consumes the synaptic weights, threshold, leak and refractory settings held in the configuration registers. Once per timestep it integrates the weighted input spikes into a saturating signed membrane potential. When the potential crosses threshold it emits a one-cycle output spike and enters a programmable refractory period.

---
 rtl/rsnn_pkg.sv | 14 +
 rtl/lif_synapse_sum.sv | 20 ++
 rtl/lif_neuron.sv | 69 ++++++
 tb/tb_lif_neuron.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rsnn_pkg.sv
// rsnn_pkg: shared widths, LIF state encoding and signed saturation for the RSNN core
package rsnn_pkg;
  localparam int N_IN = 4;
  localparam int W_WIDTH = 3;
  localparam int V_WIDTH = 8;
  localparam int REFRAC_WIDTH = 3;
  typedef enum logic {INTEGRATE, REFRACT} lif_state_t;
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return x > hi ? hi : (x < lo ? lo : x);
  endfunction
endpackage

// File: rtl/lif_synapse_sum.sv
// lif_synapse_sum: masked signed sum of the weights whose input spike is set
// spike_in: per-synapse spikes; weights: packed signed weights; sum: signed total, wide enough never to overflow
module lif_synapse_sum #(
  parameter int N_IN = rsnn_pkg::N_IN,
  parameter int W_WIDTH = rsnn_pkg::W_WIDTH,
  parameter int S_WIDTH = rsnn_pkg::V_WIDTH + $clog2(rsnn_pkg::N_IN) + 1
) (
  input  logic [N_IN-1:0]                spike_in,
  input  logic [N_IN*W_WIDTH-1:0]        weights,
  output logic signed [S_WIDTH-1:0]      sum
);
  logic signed [W_WIDTH-1:0] w [N_IN];
  for (genvar g = 0; g < N_IN; g++) begin : g_w
    assign w[g] = weights[g*W_WIDTH +: W_WIDTH];
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) sum = sum + (spike_in[i] ? S_WIDTH'(w[i]) : '0);
  end
endmodule

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with saturating membrane and programmable refractory period
// clk/rst_n: clock, async active-low reset; step: timestep strobe, the only cycle any state changes
// spike_in/weights: synaptic inputs and packed signed weights; threshold/leak_shift/refrac_len: configuration
// spike_out: one-cycle fire pulse; membrane: signed potential; refractory: high while deaf after a spike
module lif_neuron #(
  parameter int N_IN = rsnn_pkg::N_IN,
  parameter int W_WIDTH = rsnn_pkg::W_WIDTH,
  parameter int V_WIDTH = rsnn_pkg::V_WIDTH,
  parameter int REFRAC_WIDTH = rsnn_pkg::REFRAC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step,
  input  logic [N_IN-1:0]            spike_in,
  input  logic [N_IN*W_WIDTH-1:0]    weights,
  input  logic [V_WIDTH-2:0]         threshold,
  input  logic [2:0]                 leak_shift,
  input  logic [REFRAC_WIDTH-1:0]    refrac_len,
  output logic                       spike_out,
  output logic signed [V_WIDTH-1:0]  membrane,
  output logic                       refractory
);
  import rsnn_pkg::*;
  localparam int S_WIDTH = V_WIDTH + $clog2(N_IN) + 1;
  lif_state_t state, state_n;
  logic [REFRAC_WIDTH-1:0] cnt, cnt_n;
  logic signed [S_WIDTH-1:0] sum, total;
  logic signed [V_WIDTH-1:0] leaked, v_next, mem_n;
  logic spike_n, fire;
  lif_synapse_sum #(.N_IN(N_IN), .W_WIDTH(W_WIDTH), .S_WIDTH(S_WIDTH)) u_sum (
    .spike_in(spike_in),
    .weights(weights),
    .sum(sum)
  );
  assign leaked = leak_shift == 3'd0 ? membrane : membrane - (membrane >>> leak_shift);
  assign total = S_WIDTH'(leaked) + sum;
  assign v_next = V_WIDTH'(saturate(32'(total), V_WIDTH));
  assign fire = v_next >= $signed({1'b0, threshold});
  assign refractory = state == REFRACT;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mem_n = membrane;
    spike_n = 1'b0;
    if (step && state == INTEGRATE) begin
      spike_n = fire;
      mem_n = fire ? '0 : v_next;
      state_n = fire && refrac_len != '0 ? REFRACT : INTEGRATE;
      cnt_n = fire ? refrac_len : cnt;
    end else if (step) begin
      mem_n = '0;
      cnt_n = cnt - REFRAC_WIDTH'(1);
      state_n = cnt == REFRAC_WIDTH'(1) ? INTEGRATE : REFRACT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INTEGRATE;
      cnt <= '0;
      membrane <= '0;
      spike_out <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      membrane <= mem_n;
      spike_out <= spike_n;
    end
  end
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: randomized and directed checks of lif_neuron against an integer behavioural model
module tb_lif_neuron;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step = 1'b0;
  logic [3:0] spike_in = '0;
  logic [11:0] weights = '0;
  logic [6:0] threshold = '0;
  logic [2:0] leak_shift = '0;
  logic [2:0] refrac_len = '0;
  logic spike_out, refractory;
  logic signed [7:0] membrane;
  int checks = 0;
  int failures = 0;
  int m_v = 0;
  int m_ref = 0;
  int m_spk = 0;
  always #5 clk = ~clk;
  lif_neuron dut (
    .clk(clk), .rst_n(rst_n), .step(step), .spike_in(spike_in), .weights(weights),
    .threshold(threshold), .leak_shift(leak_shift), .refrac_len(refrac_len),
    .spike_out(spike_out), .membrane(membrane), .refractory(refractory)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int wt(input int i);
    logic signed [2:0] w;
    w = weights[i*3 +: 3];
    return int'(w);
  endfunction
  task automatic model_step();
    int lk, s, nv;
    if (m_ref > 0) begin
      m_ref--;
      m_v = 0;
      m_spk = 0;
    end else begin
      lk = leak_shift == 0 ? m_v : m_v - (m_v >>> leak_shift);
      s = 0;
      for (int i = 0; i < 4; i++) if (spike_in[i]) s += wt(i);
      nv = lk + s;
      nv = nv > 127 ? 127 : (nv < -128 ? -128 : nv);
      if (nv >= int'(threshold)) begin
        m_spk = 1;
        m_v = 0;
        m_ref = int'(refrac_len);
      end else begin
        m_spk = 0;
        m_v = nv;
      end
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".mem"}, int'(membrane), m_v);
    check({tag, ".spk"}, int'(spike_out), m_spk);
    check({tag, ".ref"}, int'(refractory), int'(m_ref > 0));
  endtask
  task automatic do_step(input logic [3:0] sp, input string tag);
    @(negedge clk);
    spike_in = sp;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    model_step();
    check_all(tag);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      spike_in = 4'($urandom);
      m_spk = 0;
      check_all("idle");
    end
  endtask
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_v = 0;
    m_ref = 0;
    m_spk = 0;
    check_all(tag);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask
  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weights = {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
  endtask
  initial begin
    int exp2 [4] = '{3, 6, 9, 0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all("rst");
    threshold = 7'd10;
    leak_shift = 3'd0;
    refrac_len = 3'd0;
    set_w(3, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      do_step(4'b0001, "fire");
      check("fire.const", int'(membrane), exp2[i]);
      if (i == 1) idle(5);
    end
    check("fire.pulse", int'(spike_out), 1);
    idle(1);
    for (int i = 0; i < 3; i++) do_step(4'b0001, "pre_rst");
    check("pre_rst.mem9", int'(membrane), 9);
    async_reset("rst_mid");
    check("rst_mid.mem0", int'(membrane), 0);
    threshold = 7'd3;
    refrac_len = 3'd5;
    do_step(4'b0001, "refr_in");
    do_step(4'b0001, "refr_in");
    check("refr_in.ref", int'(refractory), 1);
    async_reset("rst_refr");
    refrac_len = 3'd0;
    leak_shift = 3'd1;
    threshold = 7'd7;
    for (int i = 0; i < 6; i++) do_step(4'b0001, "leak");
    check("leak.eq", int'(membrane), 6);
    for (int i = 0; i < 4; i++) do_step(4'b0000, "leak_dn");
    leak_shift = 3'd0;
    threshold = 7'd127;
    set_w(-4, -4, -4, -4);
    for (int i = 0; i < 11; i++) do_step(4'b1111, "sat_lo");
    check("sat_lo.const", int'(membrane), -128);
    set_w(3, 3, 3, 3);
    for (int i = 0; i < 24; i++) do_step(4'b1111, "sat_hi");
    async_reset("rst2");
    threshold = 7'd3;
    set_w(3, 0, 0, 0);
    refrac_len = 3'd2;
    for (int i = 0; i < 9; i++) begin
      do_step(4'b0001, "refr");
      check("refr.period", int'(spike_out), int'(i % 3 == 0));
    end
    async_reset("rst3");
    refrac_len = 3'd0;
    for (int i = 0; i < 4; i++) begin
      do_step(4'b0001, "b2b");
      check("b2b.spk", int'(spike_out), 1);
    end
    for (int n = 0; n < 400; n++) begin
      weights = 12'($urandom);
      threshold = 7'($urandom);
      leak_shift = 3'($urandom);
      refrac_len = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) threshold = 7'($urandom_range(0, 6));
      do_step(4'($urandom), "rnd");
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
